// File: rtl/brainhack_io_core.sv
// brainhack_io_core: Brainfuck execution core with stream IO.
// Executes one instruction per enabled cycle from an external combinational
// program ROM, operating on an external tape RAM (combinational read,
// write registered by the RAM on i_clock). '.' and ',' go through
// valid/ready streams. Loop addresses live on an internal stack; forward
// skips of '[' on a zero cell are tracked with a nesting counter.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   S_RUN      | decode and execute the instruction at pc
//   S_SKIP     | scanning forward for the ']' matching a '[' on a zero cell
//   S_OUT_WAIT | offering the current cell on the output stream
//   S_IN_WAIT  | waiting for a byte on the input stream
//   S_HALT     | clean end of program, terminal until reset
//   S_ERROR    | fault detected, o_err_code holds the cause, terminal
//
// Error codes: 00 stack overflow, 01 unmatched ']', 10 pointer
// over/underflow (PTR_WRAP=0 only), 11 unmatched '[' at end of program.

module brainhack_io_core #(
    parameter int DATA_W   = 8,
    parameter int TAPE_AW  = 8,
    parameter int PRG_AW   = 8,
    parameter int PRG_LEN  = 256,
    parameter int STACK_AW = 4,
    parameter int PTR_WRAP = 1
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_enable,
    output logic [PRG_AW-1:0]  o_prgmem_addr,
    input  logic [2:0]         i_prgmem_data,
    output logic [TAPE_AW-1:0] o_tape_addr,
    input  logic [DATA_W-1:0]  i_tape_data,
    output logic               o_tape_we,
    output logic [DATA_W-1:0]  o_tape_data,
    output logic               o_out_valid,
    output logic [DATA_W-1:0]  o_out_data,
    input  logic               i_out_ready,
    output logic               o_in_ready,
    input  logic               i_in_valid,
    input  logic [DATA_W-1:0]  i_in_data,
    output logic               o_halted,
    output logic               o_error,
    output logic [1:0]         o_err_code
);

    localparam logic [2:0] S_RUN      = 3'd0;
    localparam logic [2:0] S_SKIP     = 3'd1;
    localparam logic [2:0] S_OUT_WAIT = 3'd2;
    localparam logic [2:0] S_IN_WAIT  = 3'd3;
    localparam logic [2:0] S_HALT     = 3'd4;
    localparam logic [2:0] S_ERROR    = 3'd5;

    localparam logic [2:0] OP_OUT   = 3'b000;
    localparam logic [2:0] OP_IN    = 3'b001;
    localparam logic [2:0] OP_INC   = 3'b010;
    localparam logic [2:0] OP_DEC   = 3'b011;
    localparam logic [2:0] OP_RIGHT = 3'b100;
    localparam logic [2:0] OP_LEFT  = 3'b101;
    localparam logic [2:0] OP_OPEN  = 3'b110;
    localparam logic [2:0] OP_CLOSE = 3'b111;

    localparam logic [1:0] E_STACK_OVF  = 2'b00;
    localparam logic [1:0] E_UNM_CLOSE  = 2'b01;
    localparam logic [1:0] E_PTR        = 2'b10;
    localparam logic [1:0] E_UNM_OPEN   = 2'b11;

    localparam int             DEPTH   = 2 ** STACK_AW;
    // pc carries one extra bit so that pc==PRG_LEN is representable even
    // when the program fills the whole ROM address space.
    localparam logic [PRG_AW:0]   PC_END  = (PRG_AW + 1)'(PRG_LEN);
    localparam logic [STACK_AW:0] SP_FULL = (STACK_AW + 1)'(DEPTH);

    logic [2:0]          state_q, state_d;
    logic [PRG_AW:0]     pc_q, pc_d;
    logic [TAPE_AW-1:0]  ptr_q, ptr_d;
    logic [STACK_AW:0]   sp_q, sp_d;
    logic [PRG_AW:0]     skip_q, skip_d;
    logic [1:0]          code_q, code_d;
    logic [PRG_AW-1:0]   stack_q [DEPTH];

    logic                push_en;
    logic                wr_req;
    logic [DATA_W-1:0]   wr_data;
    logic                at_end;
    logic                cell_zero;
    logic [PRG_AW:0]     pc_inc;
    logic [STACK_AW-1:0] top_idx;

    assign at_end    = (pc_q == PC_END);
    assign cell_zero = (i_tape_data == '0);
    assign pc_inc    = pc_q + (PRG_AW + 1)'(1);
    assign top_idx   = sp_q[STACK_AW-1:0] - STACK_AW'(1);

    // Next-state decode: one instruction per cycle in RUN, forward scan in SKIP,
    // stream handshakes in the wait states; HALT/ERROR hold everything.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ptr_d   = ptr_q;
        sp_d    = sp_q;
        skip_d  = skip_q;
        code_d  = code_q;
        push_en = 1'b0;
        wr_req  = 1'b0;
        wr_data = '0;
        case (state_q)
            S_RUN: begin
                if (at_end) begin
                    state_d = S_HALT;
                end else begin
                    case (i_prgmem_data)
                        OP_INC: begin
                            wr_req  = 1'b1;
                            wr_data = i_tape_data + DATA_W'(1);
                            pc_d    = pc_inc;
                        end
                        OP_DEC: begin
                            wr_req  = 1'b1;
                            wr_data = i_tape_data - DATA_W'(1);
                            pc_d    = pc_inc;
                        end
                        OP_RIGHT: begin
                            if (PTR_WRAP == 0 && ptr_q == '1) begin
                                state_d = S_ERROR;
                                code_d  = E_PTR;
                            end else begin
                                ptr_d = ptr_q + TAPE_AW'(1);
                                pc_d  = pc_inc;
                            end
                        end
                        OP_LEFT: begin
                            if (PTR_WRAP == 0 && ptr_q == '0) begin
                                state_d = S_ERROR;
                                code_d  = E_PTR;
                            end else begin
                                ptr_d = ptr_q - TAPE_AW'(1);
                                pc_d  = pc_inc;
                            end
                        end
                        OP_OPEN: begin
                            if (cell_zero) begin
                                skip_d  = (PRG_AW + 1)'(1);
                                pc_d    = pc_inc;
                                state_d = S_SKIP;
                            end else if (sp_q == SP_FULL) begin
                                state_d = S_ERROR;
                                code_d  = E_STACK_OVF;
                            end else begin
                                push_en = 1'b1;
                                sp_d    = sp_q + (STACK_AW + 1)'(1);
                                pc_d    = pc_inc;
                            end
                        end
                        OP_CLOSE: begin
                            if (sp_q == '0) begin
                                state_d = S_ERROR;
                                code_d  = E_UNM_CLOSE;
                            end else if (!cell_zero) begin
                                // Loop again: jump to the body start, keep the entry.
                                pc_d = {1'b0, stack_q[top_idx]};
                            end else begin
                                sp_d = sp_q - (STACK_AW + 1)'(1);
                                pc_d = pc_inc;
                            end
                        end
                        OP_OUT: state_d = S_OUT_WAIT;
                        OP_IN:  state_d = S_IN_WAIT;
                        default: state_d = S_RUN;
                    endcase
                end
            end
            S_SKIP: begin
                if (at_end) begin
                    state_d = S_ERROR;
                    code_d  = E_UNM_OPEN;
                end else begin
                    pc_d = pc_inc;
                    if (i_prgmem_data == OP_OPEN) begin
                        skip_d = skip_q + (PRG_AW + 1)'(1);
                    end else if (i_prgmem_data == OP_CLOSE) begin
                        skip_d = skip_q - (PRG_AW + 1)'(1);
                        if (skip_q == (PRG_AW + 1)'(1)) begin
                            state_d = S_RUN;
                        end
                    end
                end
            end
            S_OUT_WAIT: begin
                if (i_out_ready) begin
                    state_d = S_RUN;
                    pc_d    = pc_inc;
                end
            end
            S_IN_WAIT: begin
                if (i_in_valid) begin
                    wr_req  = 1'b1;
                    wr_data = i_in_data;
                    pc_d    = pc_inc;
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    // Architectural state; i_enable low freezes every register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= S_RUN;
            pc_q    <= '0;
            ptr_q   <= '0;
            sp_q    <= '0;
            skip_q  <= '0;
            code_q  <= '0;
        end else if (i_enable) begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ptr_q   <= ptr_d;
            sp_q    <= sp_d;
            skip_q  <= skip_d;
            code_q  <= code_d;
        end
    end

    // Loop stack storage; contents are meaningless above sp so no reset is needed.
    always_ff @(posedge i_clock) begin
        if (!i_reset && i_enable && push_en) begin
            stack_q[sp_q[STACK_AW-1:0]] <= pc_inc[PRG_AW-1:0];
        end
    end

    assign o_prgmem_addr = pc_q[PRG_AW-1:0];
    assign o_tape_addr   = ptr_q;
    // Writes are suppressed while frozen or in reset so the RAM never sees
    // a half-decoded instruction.
    assign o_tape_we     = wr_req && i_enable && !i_reset;
    assign o_tape_data   = o_tape_we ? wr_data : '0;
    assign o_out_valid   = (state_q == S_OUT_WAIT);
    assign o_out_data    = o_out_valid ? i_tape_data : '0;
    assign o_in_ready    = (state_q == S_IN_WAIT);
    assign o_halted      = (state_q == S_HALT);
    assign o_error       = (state_q == S_ERROR);
    assign o_err_code    = code_q;

endmodule

// File: tb/tb_brainhack_io_core.sv
// tb_brainhack_io_core: directed tests for brainhack_io_core.
// u_a: PRG_LEN=12, PTR_WRAP=1.  u_b: PRG_LEN=256, PTR_WRAP=0.
// Unused ROM words are filled with '>' so short programs run out to PRG_LEN.

module tb_brainhack_io_core;

    logic clk = 1'b0;
    logic rst, en, out_ready, in_valid;
    logic [7:0] in_data;

    logic [7:0] pa_a, ta_a, tdi_a, td_a, od_a;
    logic [2:0] pd_a;
    logic       we_a, ov_a, ir_a, h_a, e_a;
    logic [1:0] c_a;
    logic [7:0] pa_b, ta_b, tdi_b, td_b, od_b;
    logic [2:0] pd_b;
    logic       we_b, ov_b, ir_b, h_b, e_b;
    logic [1:0] c_b;

    logic [2:0] rom_a [256];
    logic [2:0] rom_b [256];
    logic [7:0] tape_a [256];
    logic [7:0] tape_b [256];

    int checks = 0;
    int fails  = 0;
    int cnt_a = 0, cnt_b = 0;
    logic [7:0] last_a = 8'h00, last_b = 8'h00;

    always #5 clk = ~clk;

    brainhack_io_core #(.DATA_W(8), .TAPE_AW(8), .PRG_AW(8), .PRG_LEN(12),
                        .STACK_AW(4), .PTR_WRAP(1)) u_a (
        .i_clock(clk), .i_reset(rst), .i_enable(en),
        .o_prgmem_addr(pa_a), .i_prgmem_data(pd_a),
        .o_tape_addr(ta_a), .i_tape_data(tdi_a),
        .o_tape_we(we_a), .o_tape_data(td_a),
        .o_out_valid(ov_a), .o_out_data(od_a), .i_out_ready(out_ready),
        .o_in_ready(ir_a), .i_in_valid(in_valid), .i_in_data(in_data),
        .o_halted(h_a), .o_error(e_a), .o_err_code(c_a)
    );

    brainhack_io_core #(.DATA_W(8), .TAPE_AW(8), .PRG_AW(8), .PRG_LEN(256),
                        .STACK_AW(4), .PTR_WRAP(0)) u_b (
        .i_clock(clk), .i_reset(rst), .i_enable(en),
        .o_prgmem_addr(pa_b), .i_prgmem_data(pd_b),
        .o_tape_addr(ta_b), .i_tape_data(tdi_b),
        .o_tape_we(we_b), .o_tape_data(td_b),
        .o_out_valid(ov_b), .o_out_data(od_b), .i_out_ready(out_ready),
        .o_in_ready(ir_b), .i_in_valid(in_valid), .i_in_data(in_data),
        .o_halted(h_b), .o_error(e_b), .o_err_code(c_b)
    );

    // Combinational ROM / tape reads, registered tape writes.
    assign pd_a  = rom_a[pa_a];
    assign pd_b  = rom_b[pa_b];
    assign tdi_a = tape_a[ta_a];
    assign tdi_b = tape_b[ta_b];

    always @(posedge clk) begin
        if (we_a) tape_a[ta_a] <= td_a;
        if (we_b) tape_b[ta_b] <= td_b;
    end

    // Output-stream monitor: counts accepted bytes, sampled 1 ns after negedge.
    always begin
        @(negedge clk);
        #1;
        if (!rst && en && out_ready) begin
            if (ov_a) begin cnt_a++; last_a = od_a; end
            if (ov_b) begin cnt_b++; last_b = od_b; end
        end
    end

    function automatic logic [2:0] enc(input byte c);
        case (c)
            ".":     return 3'b000;
            ",":     return 3'b001;
            "+":     return 3'b010;
            "-":     return 3'b011;
            ">":     return 3'b100;
            "<":     return 3'b101;
            "[":     return 3'b110;
            "]":     return 3'b111;
            default: return 3'b100;
        endcase
    endfunction

    task automatic load(input bit sel_b, input string prog);
        for (int i = 0; i < 256; i++) begin
            if (sel_b) rom_b[i] = 3'b100; else rom_a[i] = 3'b100;
        end
        for (int i = 0; i < prog.len(); i++) begin
            if (sel_b) rom_b[i] = enc(prog[i]); else rom_a[i] = enc(prog[i]);
        end
    endtask

    task automatic clear_tapes();
        for (int i = 0; i < 256; i++) begin
            tape_a[i] = 8'h00;
            tape_b[i] = 8'h00;
        end
    endtask

    // Ends at a negedge with reset released; the next posedge runs pc 0.
    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        clear_tapes();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cnt_a = 0;
        cnt_b = 0;
    endtask

    task automatic test_reset();
        load(0, "+");
        load(1, "+.");
        @(negedge clk);
        rst = 1'b1; en = 1'b1; out_ready = 1'b0; in_valid = 1'b0;
        clear_tapes();
        @(negedge clk);
        #1;
        checks++;
        if ({pa_a, ta_a, we_a, td_a, ov_a, od_a, ir_a, h_a, e_a, c_a} !== '0) begin
            fails++;
            $display("FAIL reset_a: got pc=%0d ptr=%0d we=%0b wd=%0h v=%0b od=%0h r=%0b h=%0b e=%0b c=%0d, want all 0",
                     pa_a, ta_a, we_a, td_a, ov_a, od_a, ir_a, h_a, e_a, c_a);
        end
        checks++;
        if ({pa_b, ta_b, we_b, td_b, ov_b, od_b, ir_b, h_b, e_b, c_b} !== '0) begin
            fails++;
            $display("FAIL reset_b: got pc=%0d ptr=%0d we=%0b wd=%0h v=%0b od=%0h r=%0b h=%0b e=%0b c=%0d, want all 0",
                     pa_b, ta_b, we_b, td_b, ov_b, od_b, ir_b, h_b, e_b, c_b);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({we_b, td_b} !== {1'b1, 8'h01}) begin
            fails++;
            $display("FAIL first_issue: got we=%0b wd=%0h, want we=1 wd=01", we_b, td_b);
        end
    endtask

    task automatic test_loop_mult();
        int n;
        load(0, "+++[>++<-]>.");
        pulse_reset();
        out_ready = 1'b1;
        n = 0;
        while (!h_a && !e_a && n < 200) begin @(negedge clk); #1; n++; end
        checks++;
        if ({h_a, e_a} !== 2'b10) begin
            fails++;
            $display("FAIL mult_halt: got halted=%0b error=%0b, want halted=1 error=0", h_a, e_a);
        end
        checks++;
        if (cnt_a !== 1 || last_a !== 8'd6) begin
            fails++;
            $display("FAIL mult_out: got %0d bytes last=%0d, want 1 byte of 6", cnt_a, last_a);
        end
        checks++;
        if (tape_a[0] !== 8'd0 || tape_a[1] !== 8'd6) begin
            fails++;
            $display("FAIL mult_tape: got t0=%0d t1=%0d, want t0=0 t1=6", tape_a[0], tape_a[1]);
        end
        // Terminal state: no further writes or stream activity.
        repeat (3) begin @(negedge clk); #1; end
        checks++;
        if ({h_a, we_a, ov_a, ir_a} !== 4'b1000) begin
            fails++;
            $display("FAIL halt_hold: got h=%0b we=%0b v=%0b r=%0b, want 1 0 0 0", h_a, we_a, ov_a, ir_a);
        end
    endtask

    task automatic test_ptr_wrap();
        int n;
        load(0, "<");
        pulse_reset();
        @(negedge clk);
        #1;
        checks++;
        if ({ta_a, e_a} !== {8'd255, 1'b0}) begin
            fails++;
            $display("FAIL wrap_left: got ptr=%0d err=%0b, want ptr=255 err=0", ta_a, e_a);
        end
        n = 0;
        while (!h_a && !e_a && n < 50) begin @(negedge clk); #1; n++; end
        checks++;
        if ({h_a, e_a, ta_a} !== {1'b1, 1'b0, 8'd10}) begin
            fails++;
            $display("FAIL wrap_run: got h=%0b e=%0b ptr=%0d, want h=1 e=0 ptr=10", h_a, e_a, ta_a);
        end
    endtask

    task automatic test_reset_mid_out();
        int n;
        load(0, "+.");
        pulse_reset();
        out_ready = 1'b0;
        n = 0;
        while (!ov_a && n < 20) begin @(negedge clk); #1; n++; end
        checks++;
        if ({ov_a, od_a} !== {1'b1, 8'd1}) begin
            fails++;
            $display("FAIL mid_out_valid: got v=%0b d=%0d, want v=1 d=1", ov_a, od_a);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({pa_a, ta_a, we_a, td_a, ov_a, od_a, ir_a, h_a, e_a, c_a} !== '0) begin
            fails++;
            $display("FAIL mid_out_reset: got pc=%0d ptr=%0d we=%0b v=%0b od=%0h r=%0b h=%0b e=%0b, want all 0",
                     pa_a, ta_a, we_a, ov_a, od_a, ir_a, h_a, e_a);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        cnt_a = 0;
        n = 0;
        while (!h_a && !e_a && n < 50) begin @(negedge clk); #1; n++; end
        checks++;
        if ({h_a, e_a} !== 2'b10 || cnt_a !== 1 || last_a !== 8'd2 || tape_a[0] !== 8'd2) begin
            fails++;
            $display("FAIL mid_out_restart: got h=%0b e=%0b bytes=%0d last=%0d t0=%0d, want h=1 e=0 bytes=1 last=2 t0=2",
                     h_a, e_a, cnt_a, last_a, tape_a[0]);
        end
    endtask

    task automatic test_io_echo();
        int n;
        load(1, ",.");
        out_ready = 1'b0;
        pulse_reset();
        n = 0;
        while (!ir_b && n < 10) begin @(negedge clk); #1; n++; end
        checks++;
        if ({ir_b, ov_b, we_b, pa_b} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
            fails++;
            $display("FAIL in_wait: got r=%0b v=%0b we=%0b pc=%0d, want r=1 v=0 we=0 pc=0", ir_b, ov_b, we_b, pa_b);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h41;
        #1;
        checks++;
        if ({we_b, td_b} !== {1'b1, 8'h41}) begin
            fails++;
            $display("FAIL in_write: got we=%0b wd=%0h, want we=1 wd=41", we_b, td_b);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!ov_b && n < 10) begin @(negedge clk); #1; n++; end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({ov_b, od_b, pa_b} !== {1'b1, 8'h41, 8'd1}) begin
                fails++;
                $display("FAIL out_hold%0d: got v=%0b d=%0h pc=%0d, want v=1 d=41 pc=1", i, ov_b, od_b, pa_b);
            end
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        out_ready = 1'b1;
        n = 0;
        while (!h_b && !e_b && n < 400) begin @(negedge clk); #1; n++; end
        checks++;
        if ({h_b, e_b} !== 2'b10 || cnt_b !== 1 || last_b !== 8'h41 || tape_b[0] !== 8'h41) begin
            fails++;
            $display("FAIL echo_end: got h=%0b e=%0b bytes=%0d last=%0h t0=%0h, want h=1 e=0 bytes=1 last=41 t0=41",
                     h_b, e_b, cnt_b, last_b, tape_b[0]);
        end
    endtask

    task automatic test_skip_nested();
        int n;
        load(1, "[[+]+]+.]");
        out_ready = 1'b1;
        pulse_reset();
        repeat (2) begin @(negedge clk); #1; end
        checks++;
        if ({pa_b, we_b} !== {8'd2, 1'b0}) begin
            fails++;
            $display("FAIL skip_ignore: got pc=%0d we=%0b, want pc=2 we=0", pa_b, we_b);
        end
        repeat (4) begin @(negedge clk); #1; end
        checks++;
        if ({pa_b, we_b, td_b} !== {8'd6, 1'b1, 8'd1}) begin
            fails++;
            $display("FAIL skip_exit: got pc=%0d we=%0b wd=%0d, want pc=6 we=1 wd=1", pa_b, we_b, td_b);
        end
        n = 0;
        while (!e_b && !h_b && n < 50) begin @(negedge clk); #1; n++; end
        checks++;
        if ({e_b, c_b, pa_b} !== {1'b1, 2'b01, 8'd8} || cnt_b !== 1 || last_b !== 8'd1 || tape_b[0] !== 8'd1) begin
            fails++;
            $display("FAIL skip_result: got e=%0b c=%0d pc=%0d bytes=%0d last=%0d t0=%0d, want e=1 c=1 pc=8 bytes=1 last=1 t0=1",
                     e_b, c_b, pa_b, cnt_b, last_b, tape_b[0]);
        end
    endtask

    task automatic test_stack_overflow();
        int n;
        load(1, "+");
        for (int i = 1; i <= 17; i++) rom_b[i] = 3'b110;
        pulse_reset();
        n = 0;
        while (!e_b && !h_b && n < 50) begin @(negedge clk); #1; n++; end
        checks++;
        if ({e_b, c_b, pa_b} !== {1'b1, 2'b00, 8'd17}) begin
            fails++;
            $display("FAIL overflow: got e=%0b c=%0d pc=%0d, want e=1 c=0 pc=17", e_b, c_b, pa_b);
        end
        repeat (3) begin @(negedge clk); #1; end
        checks++;
        if ({e_b, c_b, pa_b, we_b, ov_b, ir_b} !== {1'b1, 2'b00, 8'd17, 3'b000}) begin
            fails++;
            $display("FAIL overflow_hold: got e=%0b c=%0d pc=%0d we=%0b v=%0b r=%0b, want e=1 c=0 pc=17 0 0 0",
                     e_b, c_b, pa_b, we_b, ov_b, ir_b);
        end
    endtask

    task automatic test_ptr_fault();
        int n;
        load(1, "<");
        pulse_reset();
        n = 0;
        while (!e_b && !h_b && n < 10) begin @(negedge clk); #1; n++; end
        checks++;
        if ({e_b, c_b, pa_b, ta_b} !== {1'b1, 2'b10, 8'd0, 8'd0}) begin
            fails++;
            $display("FAIL ptr_fault: got e=%0b c=%0d pc=%0d ptr=%0d, want e=1 c=2 pc=0 ptr=0", e_b, c_b, pa_b, ta_b);
        end
    endtask

    task automatic test_dec_wrap();
        int n;
        load(1, "-");
        pulse_reset();
        #1;
        checks++;
        if ({we_b, td_b} !== {1'b1, 8'd255}) begin
            fails++;
            $display("FAIL dec_wrap: got we=%0b wd=%0d, want we=1 wd=255", we_b, td_b);
        end
        // 255 pad '>' take ptr to exactly 255 without a fault, then halt.
        n = 0;
        while (!h_b && !e_b && n < 400) begin @(negedge clk); #1; n++; end
        checks++;
        if ({h_b, e_b, ta_b} !== {1'b1, 1'b0, 8'd255} || tape_b[0] !== 8'd255) begin
            fails++;
            $display("FAIL dec_run: got h=%0b e=%0b ptr=%0d t0=%0d, want h=1 e=0 ptr=255 t0=255", h_b, e_b, ta_b, tape_b[0]);
        end
    endtask

    task automatic test_unmatched();
        int n;
        load(1, "]");
        pulse_reset();
        n = 0;
        while (!e_b && !h_b && n < 10) begin @(negedge clk); #1; n++; end
        checks++;
        if ({e_b, c_b, pa_b} !== {1'b1, 2'b01, 8'd0}) begin
            fails++;
            $display("FAIL unmatched_close: got e=%0b c=%0d pc=%0d, want e=1 c=1 pc=0", e_b, c_b, pa_b);
        end
        load(1, "[");
        pulse_reset();
        n = 0;
        while (!e_b && !h_b && n < 400) begin @(negedge clk); #1; n++; end
        checks++;
        if ({e_b, h_b, c_b, pa_b} !== {1'b1, 1'b0, 2'b11, 8'd0} || n < 200) begin
            fails++;
            $display("FAIL unmatched_open: got e=%0b h=%0b c=%0d pc=%0d cycles=%0d, want e=1 h=0 c=3 pc=0 (256 wrapped) after ~256 cycles",
                     e_b, h_b, c_b, pa_b, n);
        end
    endtask

    task automatic test_enable();
        int n;
        load(1, "+.");
        out_ready = 1'b0;
        en = 1'b0;
        pulse_reset();
        repeat (3) begin @(negedge clk); #1; end
        checks++;
        if ({pa_b, we_b} !== {8'd0, 1'b0} || tape_b[0] !== 8'd0) begin
            fails++;
            $display("FAIL enable_freeze: got pc=%0d we=%0b t0=%0d, want pc=0 we=0 t0=0", pa_b, we_b, tape_b[0]);
        end
        @(negedge clk);
        en = 1'b1;
        #1;
        checks++;
        if ({we_b, td_b} !== {1'b1, 8'd1}) begin
            fails++;
            $display("FAIL enable_resume: got we=%0b wd=%0d, want we=1 wd=1", we_b, td_b);
        end
        n = 0;
        while (!ov_b && n < 10) begin @(negedge clk); #1; n++; end
        @(negedge clk);
        en = 1'b0;
        out_ready = 1'b1;
        repeat (3) begin @(negedge clk); #1; end
        checks++;
        if ({ov_b, pa_b} !== {1'b1, 8'd1} || cnt_b !== 0) begin
            fails++;
            $display("FAIL enable_out_hold: got v=%0b pc=%0d bytes=%0d, want v=1 pc=1 bytes=0", ov_b, pa_b, cnt_b);
        end
        @(negedge clk);
        en = 1'b1;
        n = 0;
        while (!h_b && !e_b && n < 400) begin @(negedge clk); #1; n++; end
        checks++;
        if ({h_b, e_b} !== 2'b10 || cnt_b !== 1 || last_b !== 8'd1) begin
            fails++;
            $display("FAIL enable_end: got h=%0b e=%0b bytes=%0d last=%0d, want h=1 e=0 bytes=1 last=1", h_b, e_b, cnt_b, last_b);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, want normal completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b1; out_ready = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        load(0, "+");
        load(1, "+");
        clear_tapes();
        test_reset();
        test_loop_mult();
        test_ptr_wrap();
        test_reset_mid_out();
        test_io_echo();
        test_skip_nested();
        test_stack_overflow();
        test_ptr_fault();
        test_dec_wrap();
        test_unmatched();
        test_enable();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
